// File: rtl/max_point_finder_if.sv
// Point stream in, ranked result out, for max_point_finder.
interface max_point_finder_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x;
    logic [7:0]  in_y;
    logic [3:0]  in_w;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_idx;
    logic [16:0] out_d;
    logic        busy;

    // Producer/consumer side (drives points, takes results)
    modport master (
        output in_valid, in_x, in_y, in_w, in_last, out_ready,
        input  in_ready, out_valid, out_idx, out_d, busy
    );

    // Block side
    modport slave (
        input  in_valid, in_x, in_y, in_w, in_last, out_ready,
        output in_ready, out_valid, out_idx, out_d, busy
    );
endinterface

// File: rtl/max_point_finder.sv
// Collects up to N_PTS points, computes d = x^2 + y^2 with one shared
// multiplier, then scans the set and reports the winning index and key.
module max_point_finder #(
    parameter int unsigned N_PTS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    max_point_finder_if.slave bus
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned CRD_W = 8;
    localparam int unsigned WGT_W = 4;
    localparam int unsigned SQ_W  = 16;
    localparam int unsigned D_W   = 17;
    localparam int unsigned KEY_W = D_W + 2 * CRD_W + WGT_W;

    typedef struct packed {
        logic [CRD_W-1:0] x;
        logic [CRD_W-1:0] y;
        logic [WGT_W-1:0] w;
        logic [D_W-1:0]   d;
    } entry_t;

    typedef enum logic [2:0] {
        S_LOAD,
        S_SQX,
        S_SQY,
        S_SCAN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    entry_t             ent_q [N_PTS];
    entry_t             ent_d [N_PTS];
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   best_q, best_d;
    logic [SQ_W-1:0]    acc_q, acc_d;
    logic               last_q, last_d;
    logic               out_valid_q, out_valid_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic [D_W-1:0]     out_d_q, out_d_d;
    logic               busy_q, busy_d;

    logic               in_ready_c;
    logic [IDX_W-1:0]   cur_idx_c;
    logic [IDX_W-1:0]   cand_idx_c;
    logic [CRD_W-1:0]   mul_op_c;
    logic [SQ_W-1:0]    sq_c;
    logic [D_W-1:0]     d_new_c;
    logic [KEY_W-1:0]   key_best_c;
    logic [KEY_W-1:0]   key_cand_c;
    logic               cand_wins_c;

    // Ready is a pure decode of LOAD, held low while reset is asserted
    assign in_ready_c    = rst_n && (state_q == S_LOAD);
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_d     = out_d_q;
    assign bus.busy      = busy_q;

    assign cur_idx_c  = IDX_W'(count_q);
    assign cand_idx_c = IDX_W'(ptr_q);

    // Shared squarer: x in SQX, y in SQY
    always_comb begin
        mul_op_c = ent_q[cur_idx_c].x;
        if (state_q == S_SQY) begin
            mul_op_c = ent_q[cur_idx_c].y;
        end
        sq_c    = SQ_W'(mul_op_c) * SQ_W'(mul_op_c);
        d_new_c = D_W'(acc_q) + D_W'(sq_c);
    end

    // Priority d > x > y > w is a lexicographic compare of the concatenation
    always_comb begin
        key_best_c  = {ent_q[best_q].d, ent_q[best_q].x,
                       ent_q[best_q].y, ent_q[best_q].w};
        key_cand_c  = {ent_q[cand_idx_c].d, ent_q[cand_idx_c].x,
                       ent_q[cand_idx_c].y, ent_q[cand_idx_c].w};
        cand_wins_c = key_cand_c > key_best_c;
    end

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        ent_d       = ent_q;
        count_d     = count_q;
        ptr_d       = ptr_q;
        best_d      = best_q;
        acc_d       = acc_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_d_d     = out_d_q;

        unique case (state_q)
            S_LOAD: begin
                if (bus.in_valid && in_ready_c) begin
                    ent_d[cur_idx_c].x = bus.in_x;
                    ent_d[cur_idx_c].y = bus.in_y;
                    ent_d[cur_idx_c].w = bus.in_w;
                    last_d             = bus.in_last;
                    state_d            = S_SQX;
                end
            end
            S_SQX: begin
                acc_d   = sq_c;
                state_d = S_SQY;
            end
            S_SQY: begin
                ent_d[cur_idx_c].d = d_new_c;
                count_d            = count_q + CNT_W'(1);
                if (last_q || (count_d == CNT_W'(N_PTS))) begin
                    best_d = '0;
                    ptr_d  = CNT_W'(1);
                    if (count_d > CNT_W'(1)) begin
                        state_d = S_SCAN;
                    end else begin
                        // Single point: it is the winner, no scan needed
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        out_idx_d   = '0;
                        out_d_d     = d_new_c;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_SCAN: begin
                if (cand_wins_c) begin
                    best_d = cand_idx_c;
                end
                ptr_d = ptr_q + CNT_W'(1);
                if (ptr_q == (count_q - CNT_W'(1))) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_idx_d   = best_d;
                    out_d_d     = ent_q[best_d].d;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    count_d     = '0;
                    state_d     = S_LOAD;
                    out_valid_d = 1'b0;
                    out_idx_d   = '0;
                    out_d_d     = '0;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        busy_d = (state_d != S_LOAD);
    end

    // State and register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            count_q     <= '0;
            ptr_q       <= '0;
            best_q      <= '0;
            acc_q       <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_d_q     <= '0;
            busy_q      <= 1'b0;
            for (int unsigned i = 0; i < N_PTS; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ptr_q       <= ptr_d;
            best_q      <= best_d;
            acc_q       <= acc_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_d_q     <= out_d_d;
            busy_q      <= busy_d;
            ent_q       <= ent_d;
        end
    end

endmodule

// File: tb/tb_max_point_finder.sv
// Directed bench for max_point_finder with hand-computed results.
module tb_max_point_finder;

    logic clk;
    logic rst_n;

    max_point_finder_if bus();

    max_point_finder #(.N_PTS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] px [8];
    logic [7:0] py [8];
    logic [3:0] pw [8];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_pt(input int i, input logic [7:0] x, input logic [7:0] y, input logic [3:0] w);
        px[i] = x;
        py[i] = y;
        pw[i] = w;
    endtask

    // Offer one point; returns #1 after the accepting edge
    task automatic send_point(input logic [7:0] x, input logic [7:0] y,
                              input logic [3:0] w, input logic last);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_w     = w;
        bus.in_last  = last;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Feed n points, then check latency and result (result left pending)
    task automatic run_set(input string tag, input int n, input bit use_last,
                           input int exp_idx, input int exp_d, input int exp_lat);
        int c;
        for (int i = 0; i < n; i++) begin
            send_point(px[i], py[i], pw[i], use_last && (i == n - 1));
        end
        check({tag, "_rdy_after_accept"}, 32'(bus.in_ready), 32'd0);
        c = 0;
        while (!bus.out_valid && c < 40) begin
            @(posedge clk);
            #1;
            c++;
        end
        check({tag, "_latency"}, 32'(c), 32'(exp_lat));
        check({tag, "_idx"}, 32'(bus.out_idx), 32'(exp_idx));
        check({tag, "_d"}, 32'(bus.out_d), 32'(exp_d));
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_rdy_done"}, 32'(bus.in_ready), 32'd0);
    endtask

    // Complete the result handshake and check the return to LOAD
    task automatic take_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_valid_after_take"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_rdy_after_take"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_busy_after_take"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic load_full_set();
        set_pt(0, 8'd200, 8'd200, 4'd15);   // 80000
        set_pt(1, 8'd10,  8'd20,  4'd3);    // 500
        set_pt(2, 8'd100, 8'd0,   4'd1);    // 10000
        set_pt(3, 8'd0,   8'd200, 4'd15);   // 40000
        set_pt(4, 8'd200, 8'd199, 4'd15);   // 79601
        set_pt(5, 8'd255, 8'd255, 4'd15);   // 130050
        set_pt(6, 8'd200, 8'd200, 4'd14);   // 80000
        set_pt(7, 8'd1,   8'd1,   4'd1);    // 2
    endtask

    initial begin
        logic [2:0]  hold_idx;
        logic [16:0] hold_d;
        bit          saw_valid;

        clk           = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_w      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_idx", 32'(bus.out_idx), 32'd0);
        check("rst_out_d", 32'(bus.out_d), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Distinct keys: 25, 101, 0, 50
        set_pt(0, 8'd3,  8'd4, 4'd1);
        set_pt(1, 8'd10, 8'd1, 4'd2);
        set_pt(2, 8'd0,  8'd0, 4'd0);
        set_pt(3, 8'd5,  8'd5, 4'd7);
        run_set("distinct", 4, 1'b1, 1, 101, 5);
        take_result("distinct");

        // Equal d, x decides
        set_pt(0, 8'd6, 8'd8, 4'd1);
        set_pt(1, 8'd8, 8'd6, 4'd1);
        run_set("tie_x", 2, 1'b1, 1, 100, 3);
        take_result("tie_x");

        // Equal d, x, y, w decides
        set_pt(0, 8'd6, 8'd8, 4'd3);
        set_pt(1, 8'd6, 8'd8, 4'd9);
        run_set("tie_w", 2, 1'b1, 1, 100, 3);
        take_result("tie_w");

        // Full tie keeps lowest index
        set_pt(0, 8'd6, 8'd8, 4'd5);
        set_pt(1, 8'd6, 8'd8, 4'd5);
        set_pt(2, 8'd6, 8'd8, 4'd5);
        run_set("tie_full", 3, 1'b1, 0, 100, 4);
        take_result("tie_full");

        // Single point
        set_pt(0, 8'd1, 8'd2, 4'd0);
        run_set("single", 1, 1'b1, 0, 5, 2);
        take_result("single");

        // Full set closes at count 8 without in_last, then backpressure
        load_full_set();
        run_set("full", 8, 1'b0, 5, 130050, 9);
        hold_idx = bus.out_idx;
        hold_d   = bus.out_d;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_idx", 32'(bus.out_idx), 32'd5);
            check("bp_d", 32'(bus.out_d), 32'd130050);
            check("bp_busy", 32'(bus.busy), 32'd1);
        end
        check("bp_idx_held", 32'(bus.out_idx), 32'(hold_idx));
        check("bp_d_held", 32'(bus.out_d), 32'(hold_d));
        take_result("bp");

        set_pt(0, 8'd2, 8'd2, 4'd0);
        run_set("after_bp", 1, 1'b1, 0, 8, 2);
        take_result("after_bp");

        // Reset during the 3rd scan cycle of an 8-point set
        load_full_set();
        for (int i = 0; i < 8; i++) begin
            send_point(px[i], py[i], pw[i], 1'b0);
        end
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        check("pre_rst_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_idx", 32'(bus.out_idx), 32'd0);
        check("midrst_d", 32'(bus.out_d), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        #2;
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) saw_valid = 1'b1;
        end
        check("midrst_no_valid", 32'(saw_valid), 32'd0);
        check("midrst_rdy_load", 32'(bus.in_ready), 32'd1);

        set_pt(0, 8'd0, 8'd1, 4'd0);
        set_pt(1, 8'd1, 8'd0, 4'd0);
        run_set("after_rst", 2, 1'b1, 1, 1, 3);
        take_result("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/max_point_finder.md
# max_point_finder

Sequential front-end for the point-ranking datapath. It accepts a set of up to 8 points (x, y, weight) over a valid/ready stream and computes each point's 17-bit key d = x² + y² with one shared 8×8 multiplier. It then scans the stored set using the pairwise comparator's priority rule and reports the index and key of the winning point. It produces exactly the (x, y, w, d, index) tuples the pairwise comparator consumes, and it resolves the full set internally.

## Interface
- `N_PTS`, default 8: maximum points per set; legal range 2..8; the index width is fixed at 3 bits.
- `clk` in, 1 bit: single clock, rising edge.
- `rst_n` in, 1 bit: asynchronous, active-low reset.
- `in_valid` in, 1 bit: point offered.
- `in_ready` out, 1 bit: block can accept a point.
- `in_x` in, 8 bits: unsigned x.
- `in_y` in, 8 bits: unsigned y.
- `in_w` in, 4 bits: unsigned weight.
- `in_last` in, 1 bit: this point closes the set.
- `out_valid` out, 1 bit: result available.
- `out_ready` in, 1 bit: consumer takes result.
- `out_idx` out, 3 bits: index of the winning point, in arrival order starting at 0.
- `out_d` out, 17 bits: key of the winning point.
- `busy` out, 1 bit: high in every state except LOAD.

## Operation
- Storage: register file of N_PTS entries {x[7:0], y[7:0], w[3:0], d[16:0]}, plus a 4-bit `count`.
- States: LOAD, SQX, SQY, SCAN, DONE. Reset state is LOAD.
- **LOAD**
  - `in_ready` = 1 (combinational decode of state, forced 0 while `rst_n` is low).
  - On `in_valid & in_ready`, latch x, y, w and in_last into entry `count`, then go to SQX.
- **SQX**
  - acc <= x*x (16 bits).
  - Go to SQY.
- **SQY**
  - d[count] <= acc + y*y, computed at 17 bits. The maximum value is 130050, so there is no overflow.
  - count <= count + 1.
  - If the latched in_last is set, or the new count equals N_PTS: go to SCAN if count > 1, otherwise go to DONE. In either case set best = 0 and ptr = 1.
  - Otherwise, return to LOAD.
- **SCAN**
  - Each cycle, compare candidate j = ptr against current best i.
  - Candidate wins (best <= ptr) if any of the following holds, checked in priority order:
    - d_j > d_i;
    - d equal and x_j > x_i;
    - d and x equal and y_j > y_i;
    - d, x and y equal and w_j > w_i.
  - On the reverse inequality at the same priority level, the best is kept.
  - On a full tie, the best is kept, so the lower index wins.
  - ptr <= ptr + 1. After comparing ptr = count-1, go to DONE.
- **DONE**
  - `out_valid` = 1, `out_idx` = best, `out_d` = d[best]. All three are stable until the handshake.
  - On `out_valid & out_ready`, clear count and go to LOAD.
- Extra `in_valid` assertions while `in_ready` = 0 are ignored and not stored.
- A set is never closed by the empty state: `in_last` only takes effect on an accepted point.

## Timing
- Per point: 1 accept cycle plus 2 compute cycles. `in_ready` is low during SQX and SQY.
- Let E0 be the edge accepting the final point. `out_valid` rises after edge E(count+1):
  - count = 1: after E2;
  - count = 8: after E9.
- Result handshake: LOAD is entered on the edge where `out_valid & out_ready` is seen. `in_ready` is 1 in the following cycle.
- `out_ready` held low: the block stalls in DONE indefinitely with all outputs held.
- Reset values: `in_ready` 0 while reset is asserted, then 1 in LOAD; `out_valid` 0; `out_idx` 0; `out_d` 0; `busy` 0; count 0; best 0; ptr 0.
- Reset mid-operation (any state): returns immediately to LOAD with count 0. The partial set is discarded and no result is emitted for it.

## Test plan
- Distinct keys: points (3,4,1), (10,1,2), (0,0,0), (5,5,7), with in_last on the 4th -> `out_idx` = 1, `out_d` = 101, `out_valid` after E5.
- Tie-breaks:
  - (6,8,1), (8,6,1) -> idx 1 (x wins);
  - (6,8,3), (6,8,9) -> idx 1 (w wins);
  - (6,8,5) ×3 -> idx 0 (full tie keeps the lower index).
- Full set without in_last: 8 points, (255,255,15) at index 5 and all others ≤ (200,200,15) -> set closes at count 8, `in_ready` stays low, `out_idx` = 5, `out_d` = 130050, `out_valid` after E9.
- Single point (1,2,0) with in_last -> `out_idx` = 0, `out_d` = 5, `out_valid` after E2, no SCAN cycles.
- Backpressure: hold `out_ready` low for 10 cycles -> `out_valid`, `out_idx` and `out_d` are constant and `busy` = 1. Raise `out_ready` -> `in_ready` = 1 the next cycle, and a new set {(2,2,0)} yields idx 0, d = 8.
- Reset mid-SCAN (pulse `rst_n` low during the 3rd scan cycle of an 8-point set) -> outputs return to reset values at once with no `out_valid` pulse. A following set {(0,1,0), (1,0,0)} -> idx 1, d = 1.
